// File: rtl/dmem_access_unit.sv
// Load/store access unit: byte/half/word accesses to a word-only data memory, with
// read-modify-write for sub-word stores. Define DMEM_ALIGN_CHECK_EN to reject misaligned requests.
module dmem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          lane_q, lane_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  // Holds store data after accept, then the merged word (store) or extended result (load).
  logic [31:0]         data_q, data_d;

  logic [4:0]          sh;
  logic [31:0]         shifted;
  logic [31:0]         load_val;
  logic [31:0]         lane_mask;
  logic [31:0]         merged;

  // Address bits above the memory index wrap around and are intentionally dropped.
  logic                unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic                err_q, err_d;
  logic                misaligned;
  assign misaligned = req_size_i[1] ? (req_addr_i[1:0] != 2'b00)
                                    : (req_size_i[0] & req_addr_i[0]);
`endif

  // Lane extraction and merge; a half access uses only addr[1], so bit 0 is dropped.
  always_comb begin
    sh        = size_q[1] ? 5'd0 : (size_q[0] ? {lane_q[1], 4'b0000} : {lane_q, 3'b000});
    shifted   = mem_rdata_i >> sh;
    if (size_q[1]) begin
      load_val = shifted;
    end else if (size_q[0]) begin
      load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
    end else begin
      load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
    end
    lane_mask = (size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    merged    = (mem_rdata_i & ~lane_mask) | ((data_q << sh) & lane_mask);
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    idx_d       = idx_q;
    data_d      = data_q;
`ifdef DMEM_ALIGN_CHECK_EN
    err_d       = err_q;
`endif
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d   = req_we_i;
          size_d = req_size_i;
          uns_d  = req_unsigned_i;
          lane_d = req_addr_i[1:0];
          idx_d  = req_addr_i[ADDR_W+1:2];
          data_d = req_wdata_i;
`ifdef DMEM_ALIGN_CHECK_EN
          err_d  = misaligned;
          if (misaligned) begin
            state_d = RESP;
          end else
`endif
          if (req_we_i && req_size_i[1]) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        mem_re_o   = 1'b1;
        mem_addr_o = idx_q;
        data_d     = we_q ? merged : load_val;
        state_d    = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = idx_q;
        mem_wdata_o = data_q;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
        rsp_err_o   = err_q;
        rsp_rdata_o = (we_q || err_q) ? 32'd0 : data_q;
`else
        rsp_rdata_o = we_q ? 32'd0 : data_q;
`endif
        state_d     = IDLE;
      end
    endcase

    // Outputs are forced quiet during reset so an interrupted WRITE never reaches memory.
    if (rst_i) begin
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      rsp_rdata_o = '0;
      rsp_err_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_re_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      idx_q   <= '0;
      data_q  <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed cases plus random traffic against
// a byte-array reference model; honours DMEM_ALIGN_CHECK_EN like the design.
`timescale 1ns/1ps
module tb_dmem_access_unit;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic              req_we_i = 1'b0;
  logic [1:0]        req_size_i = 2'b00;
  logic              req_unsigned_i = 1'b0;
  logic [31:0]       req_addr_i = 32'd0;
  logic [31:0]       req_wdata_i = 32'd0;
  logic              rsp_valid_o;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic              mem_we_o;
  logic              mem_re_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  dmem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Physical memory seen by the DUT, plus a preload port used only while in reset.
  bit   [31:0]       phys [1024];
  bit   [31:0]       ref_mem [1024];
  logic              pre_we = 1'b0;
  logic [9:0]        pre_idx = 10'd0;
  logic [31:0]       pre_data = 32'd0;
  assign mem_rdata_i = phys[mem_addr_o];
  always @(posedge clk) begin
    if (pre_we) phys[pre_idx] <= pre_data;
    else if (mem_we_o) phys[mem_addr_o] <= mem_wdata_o;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_txn   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected behaviour of the transaction in flight, in cycles counted from the accept edge.
  int          txn_start = -100;
  int          txn_lat   = 0;
  int          txn_re_k  = 0;
  int          txn_we_k  = 0;
  logic [31:0] exp_addr  = 32'd0;
  logic [31:0] exp_wdata = 32'd0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err   = 1'b0;
  logic        chk_en    = 1'b0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err   = 1'b0;

  always @(negedge clk) begin
    int   k;
    logic in_win, e_rsp, e_re, e_we;
    if (chk_en) begin
      k      = cyc - txn_start + 1;
      in_win = (k >= 1) && (k <= txn_lat);
      e_rsp  = in_win && (k == txn_lat);
      e_re   = in_win && (k == txn_re_k);
      e_we   = in_win && (k == txn_we_k);
      chk("req_ready", 32'(req_ready_o), 32'(!in_win));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rsp));
      chk("mem_re", 32'(mem_re_o), 32'(e_re));
      chk("mem_we", 32'(mem_we_o), 32'(e_we));
      if (e_re || e_we) chk("mem_addr", 32'(mem_addr_o), exp_addr);
      if (e_we) chk("mem_wdata", mem_wdata_o, exp_wdata);
      if (e_rsp) begin
        chk("rsp_rdata", rsp_rdata_o, exp_rdata);
        chk("rsp_err", 32'(rsp_err_o), 32'(exp_err));
        last_rdata = rsp_rdata_o;
        last_err   = rsp_err_o;
      end
    end
  end

  // Drives one request, holds it until accepted, then loads the model's expectations.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int          n, lat, rk, wk, hl, sv;
    logic [9:0]  idx;
    logic [1:0]  b;
    logic        mis, e;
    bit   [31:0] w, v, nw;
    bit   [7:0]  by [4];
    bit   [15:0] h;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      chk("accept_timeout", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;

    idx = addr[ADDR_W+1:2];
    b   = addr[1:0];
    hl  = int'(b[1]);
    mis = (size == 2'b01 && b[0]) || (size[1] && b != 2'b00);
    w   = ref_mem[idx];
    for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
    e = 1'b0; v = 32'd0; nw = w; rk = 0; wk = 0; lat = 0;
`ifdef DMEM_ALIGN_CHECK_EN
    if (mis) begin
      e = 1'b1; lat = 1;
    end else
`endif
    if (!we) begin
      lat = 2; rk = 1;
      if (size[1]) begin
        v = w;
      end else if (size[0]) begin
        h  = {by[2*hl+1], by[2*hl]};
        sv = $signed(h);
        v  = uns ? 32'(h) : 32'(sv);
      end else begin
        sv = $signed(by[b]);
        v  = uns ? 32'(by[b]) : 32'(sv);
      end
    end else begin
      if (size[1]) begin
        nw = wdata; lat = 2; wk = 1;
      end else begin
        if (size[0]) begin
          by[2*hl] = wdata[7:0]; by[2*hl+1] = wdata[15:8];
        end else begin
          by[b] = wdata[7:0];
        end
        nw = {by[3], by[2], by[1], by[0]};
        lat = 3; rk = 1; wk = 2;
      end
      ref_mem[idx] = nw;
    end

    txn_lat = lat; txn_re_k = rk; txn_we_k = wk;
    exp_addr = 32'(idx); exp_wdata = nw; exp_rdata = v; exp_err = e;
    txn_start = cyc;
    n_txn++;
    $display("[TB] txn %0d we=%0d size=%0d uns=%0d addr=%08h wdata=%08h exp_rdata=%08h exp_err=%0d lat=%0d",
             n_txn, we, size, uns, addr, wdata, v, e, lat);
    repeat (lat - 1) @(negedge clk);
  endtask

  // Advances to the response cycle of the last request, after the compare process has run.
  task automatic to_rsp();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int diffs;
    // Reset held while a load is presented; preload memory meanwhile.
    rst_i = 1'b1;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'h11; req_wdata_i = 32'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i < 3) begin
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_re", 32'(mem_re_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
      end
      pre_we = 1'b1;
      pre_idx = 10'(i);
      pre_data = (i == 4) ? 32'h8899_AABB : $urandom;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk_en = 1'b1;

    // Directed cases on word index 4 = 0x8899AABB.
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'd0); to_rsp();
    chk("lb_signed", last_rdata, 32'hFFFF_FFAA);
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'd0); to_rsp();
    chk("lbu", last_rdata, 32'h0000_00AA);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'd0); to_rsp();
    chk("lh_signed", last_rdata, 32'hFFFF_8899);
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_005C);
    chk("sb_model_merge", exp_wdata, 32'h5C99_AABB);
    to_rsp();
    chk("sb_mem", phys[4], 32'h5C99_AABB);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0); to_rsp();
    chk("lw_after_sb", last_rdata, 32'h5C99_AABB);
    do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEAD_BEEF); to_rsp();
    chk("sw_wrap_mem", phys[0], 32'hDEAD_BEEF);
    do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'd0); to_rsp();
`ifdef DMEM_ALIGN_CHECK_EN
    chk("lh_misaligned_err", 32'(last_err), 32'd1);
    chk("lh_misaligned_rdata", last_rdata, 32'd0);
`else
    chk("lh_misaligned_trunc", last_rdata, 32'hFFFF_AABB);
`endif

    // Reset during the WRITE cycle of a word store to index 4.
    chk_en = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h10; req_wdata_i = 32'h1234_5678;
    chk("abort_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("abort_in_write", 32'(mem_we_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("abort_we_gated", 32'(mem_we_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("abort_idle_ready", 32'(req_ready_o), 32'd1);
    chk("abort_no_rsp", 32'(rsp_valid_o), 32'd0);
    chk("abort_mem_kept", phys[4], 32'h5C99_AABB);
    chk_en = 1'b1;

    // Random traffic over 16 words with random wrap-around upper address bits.
    for (int t = 0; t < 300; t++) begin
      logic        r_we, r_uns;
      logic [1:0]  r_size;
      logic [31:0] r_addr;
      r_we   = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_uns  = 1'($urandom_range(0, 1));
      r_addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_req(r_we, r_size, r_uns, r_addr, $urandom);
    end
    to_rsp();
    repeat (2) @(negedge clk);

    diffs = 0;
    for (int i = 0; i < 1024; i++) if (phys[i] != ref_mem[i]) diffs++;
    chk("mem_final_diffs", 32'(diffs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store access unit between the EX/MEM pipeline register and the word-addressed data memory. Accepts one byte/half/word load or store at a time, drives the memory's write-enable, read-enable, word-index address and write-data ports, and returns zero- or sign-extended load data. Sub-word stores use an internal read-modify-write sequence because the memory only writes whole words. The unit stalls the pipeline through a valid/ready handshake while a sequence is in flight.

## Interface
- ADDR_W, 10, word-index width; matches the data memory's index width (`INDEX_MSB`).
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit idle, can accept.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_unsigned_i  in  1  zero-extend load (ignored for stores).
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  32  load result; 0 for stores and errors.
- rsp_err_o  out  1  misaligned access, valid with rsp_valid_o.
- mem_we_o  out  1  to memory write enable.
- mem_re_o  out  1  to memory read enable.
- mem_addr_o  out  ADDR_W  word index = addr[ADDR_W+1:2].
- mem_wdata_o  out  32  full word to write.
- mem_rdata_i  in  32  memory read data; valid before the rising edge of the cycle in which mem_re_o and mem_addr_o are held.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready_o=1. On req_valid_i: latch we/size/unsigned/addr/wdata. Next: misaligned (with check enabled) -> RESP with err; word store -> WRITE; load or sub-word store -> READ.
- READ: mem_re_o=1, mem_addr_o from latched address; capture mem_rdata_i at edge. Load -> RESP with extracted data. Sub-word store -> WRITE with merged word.
- WRITE: mem_we_o=1, mem_wdata_o = merged word (sub-word) or latched wdata (word). -> RESP.
- RESP: rsp_valid_o=1 for exactly one cycle, req_ready_o=0. -> IDLE.
- Little-endian lanes. Byte lane = addr[1:0]; half lane = addr[1]. Extraction shifts lane to bits [7:0]/[15:0], then extends with bit 7/15 unless req_unsigned_i.
- Merge: replace only addressed byte/half lane of read word; other lanes unchanged.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Byte never misaligned.
- Address bits above ADDR_W+1 ignored (wrap-around modulo memory size).
- mem_re_o and mem_we_o never both high; both low in IDLE and RESP.
- Requests presented while req_ready_o=0 are ignored; requester holds them.

## Timing
- Reset: state IDLE; rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, mem_we_o=0, mem_re_o=0, mem_addr_o=0, mem_wdata_o=0; req_ready_o=0 while rst_i high, 1 first cycle after.
- mem_we_o/mem_re_o gated by !rst_i: reset asserted mid-WRITE performs no write.
- Accept at cycle 0 edge; rsp_valid_o high in cycle: load 2, word store 2, sub-word store 3, misaligned error 1.
- Back-to-back: next request accepted in IDLE cycle following RESP; throughput one op per 3 cycles (load/word store), 4 (sub-word store).
- Load hazard against own store impossible: one request in flight.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: misaligned requests produce rsp_err_o=1, rsp_rdata_o=0, no memory access.
- Undefined: no check, rsp_err_o tied 0; offending low address bits truncated (half uses addr[1], word uses lane 0) and access proceeds normally.

## Test plan
- Reset held 3 cycles while req_valid_i=1 -> req_ready_o=0, no mem_re_o/mem_we_o, all outputs 0; accepted only after release.
- Memory word index 4 = 0x8899AABB; load byte signed addr 0x11 -> rsp_rdata_o=0xFFFFFFAA on cycle 2; unsigned -> 0x000000AA; half signed addr 0x12 -> 0xFFFF8899.
- Store byte 0x5C to addr 0x13 -> READ then WRITE with mem_wdata_o=0x5C99AABB, rsp_valid_o on cycle 3; subsequent word load addr 0x10 returns 0x5C99AABB.
- Word store 0xDEADBEEF to addr 0x1000 with ADDR_W=10 -> mem_addr_o=0 (wrap), single WRITE cycle, no mem_re_o.
- Half load addr 0x11 with DMEM_ALIGN_CHECK_EN -> rsp_valid_o and rsp_err_o on cycle 1, no memory strobe; without macro -> returns lane 0 half 0xFFFFAABB.
- rst_i asserted during WRITE of a store to index 4 -> memory word unchanged, state IDLE next cycle, no rsp_valid_o.
